// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core: one FSM sequences fetch/decode/execute/mem/writeback over a
// single req/ready memory port. Define RISCV_MC_INSTRET_EN to add the 64-bit instret_o counter.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [31:0]           pc_o,
  output logic                  halted_o
`ifdef RISCV_MC_INSTRET_EN
  ,
  output logic [63:0]           instret_o
`endif
);

  localparam int RW = $clog2(NUM_REGS);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [2:0]  state;
  logic [31:0] pc, ir, a_q, b_q, imm_q, res_q;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        legal;
  logic [31:0] imm, rs1_val, rs2_val, alu_b, alu, addr_calc, next_pc, wb_val;
  logic        is_mem, is_store, is_branch, redirect;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign pc_o      = pc;
  assign halted_o  = (state == S_TRAP);
  assign is_store  = (opcode == OP_ST);
  assign is_mem    = (opcode == OP_LD) || is_store;
  assign is_branch = (opcode == OP_BR);

  // Registers above NUM_REGS behave like x0: read zero, writes dropped.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && int'(rs1) < NUM_REGS) rs1_val = regs[rs1[RW-1:0]];
    if (rs2 != 5'd0 && int'(rs2) < NUM_REGS) rs2_val = regs[rs2[RW-1:0]];
  end

  always_comb begin
    legal = 1'b0;
    imm   = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OP_R:   legal = (f7 == 7'h00 && (f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7})) ||
                      (f7 == 7'h20 && f3 == 3'd0);
      OP_I:   legal = f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
      OP_LD:  legal = (f3 == 3'd2);
      OP_ST: begin
        legal = (f3 == 3'd2);
        imm   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_BR: begin
        legal = (f3 == 3'd0) || (f3 == 3'd1);
        imm   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OP_JAL: begin
        legal = 1'b1;
        imm   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OP_LUI: begin
        legal = 1'b1;
        imm   = {ir[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_b = (opcode == OP_R) ? b_q : imm_q;
    case (f3)
      3'd0:    alu = (opcode == OP_R && f7[5]) ? a_q - alu_b : a_q + alu_b;
      3'd2:    alu = {31'b0, $signed(a_q) < $signed(alu_b)};
      3'd4:    alu = a_q ^ alu_b;
      3'd6:    alu = a_q | alu_b;
      3'd7:    alu = a_q & alu_b;
      default: alu = '0;
    endcase
    addr_calc = a_q + imm_q;
    redirect  = (opcode == OP_JAL) ||
                (is_branch && ((a_q == b_q) ^ f3[0]));
    next_pc   = redirect ? pc + imm_q : pc + 32'd4;
    wb_val    = (opcode == OP_LUI) ? imm_q :
                (opcode == OP_JAL) ? pc + 32'd4 : alu;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      res_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        // Request is normally launched by the state that hands over to FETCH; only the
        // first fetch after reset has to launch it here.
        S_FETCH: begin
          if (!mem_req_o) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= pc[ADDR_WIDTH-1:0];
          end else if (mem_ready_i) begin
            ir        <= mem_rdata_i;
            mem_req_o <= 1'b0;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal) state <= S_TRAP;
          else begin
            a_q   <= rs1_val;
            b_q   <= rs2_val;
            imm_q <= imm;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            if (addr_calc[1:0] != 2'b00) state <= S_TRAP;
            else begin
              pc         <= next_pc;
              mem_req_o  <= 1'b1;
              mem_we_o   <= is_store;
              mem_addr_o <= addr_calc[ADDR_WIDTH-1:0];
              if (is_store) mem_wdata_o <= b_q;
              state      <= S_MEM;
            end
          end else if (is_branch) begin
            pc         <= next_pc;
            mem_req_o  <= 1'b1;
            mem_addr_o <= next_pc[ADDR_WIDTH-1:0];
            state      <= S_FETCH;
          end else begin
            pc    <= next_pc;
            res_q <= wb_val;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready_i) begin
            mem_we_o <= 1'b0;
            if (mem_we_o) begin
              mem_addr_o <= pc[ADDR_WIDTH-1:0];
              state      <= S_FETCH;
            end else begin
              mem_req_o <= 1'b0;
              res_q     <= mem_rdata_i;
              state     <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0 && int'(rd) < NUM_REGS) regs[rd[RW-1:0]] <= res_q;
          mem_req_o  <= 1'b1;
          mem_addr_o <= pc[ADDR_WIDTH-1:0];
          state      <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_MC_INSTRET_EN
  logic retire;
  assign retire = (state == S_WB) ||
                  (state == S_MEM && mem_we_o && mem_ready_i) ||
                  (state == S_EXEC && is_branch);

  always_ff @(posedge clk) begin
    if (reset)       instret_o <= '0;
    else if (retire) instret_o <= instret_o + 64'd1;
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: ALU/immediate vector table run as tiny programs,
// plus hand sequences for timing, wait states, branches, jal, traps and reset mid-store.
module tb_riscv_multicycle_core;
  localparam logic [31:0] RP  = 32'h0040_0000;
  localparam logic [31:0] ILL = 32'h0000_007F;
  localparam logic [6:0] OPI = 7'b0010011, OLD = 7'b0000011, OLUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_o, mem_we_o, mem_ready_i, halted_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;
`ifdef RISCV_MC_INSTRET_EN
  logic [63:0] instret_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_multicycle_core dut (
    .clk(clk), .reset(reset),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .pc_o(pc_o), .halted_o(halted_o)
`ifdef RISCV_MC_INSTRET_EN
    , .instret_o(instret_o)
`endif
  );

  // Memory model: program lives at RP (bit 22 set), data near address 0.
  logic [31:0] mem [1024];
  function automatic logic [9:0] midx(input logic [31:0] a);
    return {a[22], a[10:2]};
  endfunction

  int   wcnt = 0;
  int   wait_n = 0;
  logic hold_low = 1'b0;
  int   wr_count = 0;

  assign mem_rdata_i = mem[midx(mem_addr_o)];
  assign mem_ready_i = !hold_low && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (mem_req_o && mem_we_o && mem_ready_i) begin
      mem[midx(mem_addr_o)] = mem_wdata_o;
      wr_count++;
    end
    if (!mem_req_o || mem_ready_i) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // While a request waits, its address/direction/data must not move.
  logic        hold_prev = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  always @(negedge clk) begin
    if (!reset && hold_prev) begin
      checks++;
      if (!(mem_req_o && mem_addr_o == p_addr && mem_we_o == p_we && mem_wdata_o == p_wdata)) begin
        errors++;
        $display("FAIL hold_stable: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                 mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, p_addr, p_we, p_wdata);
      end
    end
    hold_prev = mem_req_o && !mem_ready_i && !reset;
    p_addr    = mem_addr_o;
    p_we      = mem_we_o;
    p_wdata   = mem_wdata_o;
  end

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic [31:0] op, a, b, exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[midx(a)] = w;
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int maxc);
    int n = 0;
    while (!halted_o && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!halted_o) begin
      errors++;
      $display("FAIL %s: halted_o=%b after %0d cycles, expected 1", name, halted_o, maxc);
    end
  endtask

  task automatic wait_fetch(input string name, input logic [31:0] a, input int maxc);
    int n = 0;
    while (!(mem_req_o && !mem_we_o && mem_addr_o == a) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(mem_req_o && !mem_we_o && mem_addr_o == a)) begin
      errors++;
      $display("FAIL %s: fetch addr=%h req=%b, expected fetch of %h within %0d cycles",
               name, mem_addr_o, mem_req_o, a, maxc);
    end
  endtask

  vec_t vecs [16];

  initial begin
    int   reqs;
    int   wr_snap;
    vecs[0]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    vecs[1]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    vecs[2]  = mkv(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5,        32'd7,        32'hFFFF_FFFE);
    vecs[3]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd3), 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    vecs[4]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd3), 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    vecs[5]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd3), 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    vecs[6]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    vecs[7]  = mkv(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
    vecs[8]  = mkv(enc_i(32'hFFFF_FFF5, 5'd1, 3'd0, 5'd3, OPI), 32'd10, 32'd0, 32'hFFFF_FFFF);
    vecs[9]  = mkv(enc_i(32'h0000_07FF, 5'd1, 3'd7, 5'd3, OPI), 32'hFFFF_FFFF, 32'd0, 32'h0000_07FF);
    vecs[10] = mkv(enc_i(32'hFFFF_FFF0, 5'd1, 3'd7, 5'd3, OPI), 32'h1234_5678, 32'd0, 32'h1234_5670);
    vecs[11] = mkv(enc_i(32'h0000_0800, 5'd1, 3'd6, 5'd3, OPI), 32'h0000_0100, 32'd0, 32'hFFFF_F900);
    vecs[12] = mkv(enc_i(32'h0000_0FFF, 5'd1, 3'd4, 5'd3, OPI), 32'h0000_000F, 32'd0, 32'hFFFF_FFF0);
    vecs[13] = mkv(enc_i(32'h0000_0000, 5'd1, 3'd2, 5'd3, OPI), 32'h8000_0000, 32'd0, 32'h0000_0001);
    vecs[14] = mkv(enc_i(32'h0000_0005, 5'd1, 3'd2, 5'd3, OPI), 32'h0000_0005, 32'd0, 32'h0000_0000);
    vecs[15] = mkv({20'hABCDE, 5'd3, OLUI}, 32'h1111_1111, 32'h2222_2222, 32'hABCD_E000);

    // Table: lw x1; lw x2; <op> x3; sw x3,0x108; trap. Wait states rotate 0..2.
    for (int i = 0; i < 16; i++) begin
      hold_reset();
      put(32'h100, vecs[i].a);
      put(32'h104, vecs[i].b);
      put(32'h108, 32'hDEAD_BEEF);
      put(RP,      enc_i(32'h100, 5'd0, 3'd2, 5'd1, OLD));
      put(RP + 4,  enc_i(32'h104, 5'd0, 3'd2, 5'd2, OLD));
      put(RP + 8,  vecs[i].op);
      put(RP + 12, enc_s(32'h108, 5'd3, 5'd0));
      put(RP + 16, ILL);
      wait_n = i % 3;
      release_reset();
      run_to_halt($sformatf("vec%0d_halt", i), 400);
      check($sformatf("vec%0d_result", i), 64'(mem[midx(32'h108)]), 64'(vecs[i].exp));
    end
    wait_n = 0;

    // Reset values and 12-cycle timing of addi/addi/add.
    hold_reset();
    @(negedge clk);
    check("rst_req",   64'(mem_req_o),   64'd0);
    check("rst_we",    64'(mem_we_o),    64'd0);
    check("rst_addr",  64'(mem_addr_o),  64'd0);
    check("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_pc",    64'(pc_o),        64'(RP));
    check("rst_halt",  64'(halted_o),    64'd0);
`ifdef RISCV_MC_INSTRET_EN
    check("rst_instret", instret_o, 64'd0);
`endif
    put(RP,      enc_i(32'd5, 5'd0, 3'd0, 5'd1, OPI));
    put(RP + 4,  enc_i(32'hFFFF_FFFD, 5'd0, 3'd0, 5'd2, OPI));
    put(RP + 8,  enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    put(RP + 12, enc_s(32'h108, 5'd3, 5'd0));
    put(RP + 16, ILL);
    reset = 1'b0;
    @(negedge clk);
    check("t1_first_req",  64'(mem_req_o),  64'd1);
    check("t1_first_addr", 64'(mem_addr_o), 64'(RP));
    repeat (12) @(negedge clk);
    check("t1_pc_12cyc",   64'(pc_o),       64'(RP + 12));
    check("t1_addr_12cyc", 64'(mem_addr_o), 64'(RP + 12));
`ifdef RISCV_MC_INSTRET_EN
    check("t1_instret", instret_o, 64'd3);
`endif
    run_to_halt("t1_halt", 100);
    check("t1_x3", 64'(mem[midx(32'h108)]), 64'd2);

    // sw then lw with 3 wait cycles on every request.
    hold_reset();
    put(32'h0,   32'hFFFF_FFFF);
    put(RP,      enc_i(32'd5, 5'd0, 3'd0, 5'd1, OPI));
    put(RP + 4,  enc_s(32'h0, 5'd1, 5'd0));
    put(RP + 8,  enc_i(32'h0, 5'd0, 3'd2, 5'd4, OLD));
    put(RP + 12, enc_s(32'h10C, 5'd4, 5'd0));
    put(RP + 16, ILL);
    wait_n = 3;
    release_reset();
    run_to_halt("t2_halt", 400);
    check("t2_word0", 64'(mem[midx(32'h0)]),   64'd5);
    check("t2_x4",    64'(mem[midx(32'h10C)]), 64'd5);
    wait_n = 0;

    // beq x0,x0,-8 taken: three cycles from fetch to refetch at P.
    hold_reset();
    put(RP,     enc_i(32'd1, 5'd0, 3'd0, 5'd1, OPI));
    put(RP + 4, enc_i(32'd2, 5'd0, 3'd0, 5'd2, OPI));
    put(RP + 8, enc_b(32'hFFFF_FFF8, 5'd0, 5'd0, 3'd0));
    release_reset();
    wait_fetch("t3_beq_fetch", RP + 8, 100);
    repeat (2) @(negedge clk);
    check("t3_beq_noreq_exec", 64'(mem_req_o), 64'd0);
    @(negedge clk);
    check("t3_beq_pc",   64'(pc_o),       64'(RP));
    check("t3_beq_addr", 64'(mem_addr_o), 64'(RP));

    // bne x0,x0,-8 not taken: falls through to P+12.
    hold_reset();
    put(RP,      enc_i(32'd1, 5'd0, 3'd0, 5'd1, OPI));
    put(RP + 4,  enc_i(32'd2, 5'd0, 3'd0, 5'd2, OPI));
    put(RP + 8,  enc_b(32'hFFFF_FFF8, 5'd0, 5'd0, 3'd1));
    put(RP + 12, ILL);
    release_reset();
    wait_fetch("t3_bne_fetch", RP + 8, 100);
    repeat (3) @(negedge clk);
    check("t3_bne_pc",  64'(pc_o),      64'(RP + 12));
    check("t3_bne_req", 64'(mem_req_o), 64'd1);

    // jal x1,+16.
    hold_reset();
    put(32'h114, 32'hDEAD_BEEF);
    put(RP,      enc_j(32'd16, 5'd1));
    put(RP + 16, enc_s(32'h114, 5'd1, 5'd0));
    put(RP + 20, ILL);
    release_reset();
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("t4_jal_pc",   64'(pc_o),       64'(RP + 16));
    check("t4_jal_addr", 64'(mem_addr_o), 64'(RP + 16));
    run_to_halt("t4_halt", 100);
    check("t4_jal_link", 64'(mem[midx(32'h114)]), 64'(RP + 4));

    // jal x0,+16: link discarded, x0 still reads 0.
    hold_reset();
    put(32'h114, 32'hDEAD_BEEF);
    put(RP,      enc_j(32'd16, 5'd0));
    put(RP + 16, enc_s(32'h114, 5'd0, 5'd0));
    put(RP + 20, ILL);
    release_reset();
    run_to_halt("t4_x0_halt", 100);
    check("t4_x0_zero", 64'(mem[midx(32'h114)]), 64'd0);

    // Misaligned lw traps; core stays quiet until reset.
    hold_reset();
    put(RP,     enc_i(32'd1, 5'd0, 3'd0, 5'd1, OPI));
    put(RP + 4, enc_i(32'd2, 5'd0, 3'd2, 5'd5, OLD));
    put(RP + 8, enc_s(32'h11C, 5'd1, 5'd0));
    put(RP + 12, ILL);
    release_reset();
    run_to_halt("t5_misalign_halt", 100);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req_o) reqs++;
    end
    check("t5_no_req",   64'(reqs),     64'd0);
    check("t5_halted",   64'(halted_o), 64'd1);
    check("t5_pc_frz",   64'(pc_o),     64'(RP + 4));
    check("t5_no_store", 64'(mem[midx(32'h11C)]), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_rst_pc",   64'(pc_o),     64'(RP));
    check("t5_rst_halt", 64'(halted_o), 64'd0);

    // Unsupported opcode 7'h7F traps at the first instruction.
    hold_reset();
    put(RP, ILL);
    release_reset();
    run_to_halt("t5_ill_halt", 50);
    check("t5_ill_pc",  64'(pc_o),      64'(RP));
    check("t5_ill_req", 64'(mem_req_o), 64'd0);

    // Reset while a store waits in MEM: the write must never complete.
    hold_reset();
    put(RP,     enc_i(32'd5, 5'd0, 3'd0, 5'd1, OPI));
    put(RP + 4, enc_s(32'h118, 5'd1, 5'd0));
    put(RP + 8, ILL);
    release_reset();
    wait_fetch("t6_sw_fetch", RP + 4, 100);
    @(negedge clk);
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_mem_we",    64'(mem_req_o && mem_we_o), 64'd1);
    check("t6_mem_addr",  64'(mem_addr_o),  64'h118);
    check("t6_mem_wdata", 64'(mem_wdata_o), 64'd5);
    wr_snap = wr_count;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_req", 64'(mem_req_o), 64'd0);
    reset    = 1'b0;
    hold_low = 1'b0;
    @(negedge clk);
    check("t6_refetch_req",  64'(mem_req_o && !mem_we_o), 64'd1);
    check("t6_refetch_addr", 64'(mem_addr_o), 64'(RP));
    check("t6_no_write",     64'(wr_count),   64'(wr_snap));
    check("t6_mem_clean",    64'(mem[midx(32'h118)]), 64'd0);
    run_to_halt("t6_halt", 100);
    check("t6_rerun_store", 64'(mem[midx(32'h118)]), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
